ee201_clk_div_prog: RTL and testbench

Programmable, glitch-free clock/tick divider; the parametrised successor to the fixed 60 Hz divider. It derives a square-wave enable clock (or a one-cycle strobe) from the board clock, with a divisor that software or an FSM can reload at run time. New divisors take effect only at a period boundary. It feeds display refresh, debouncers and slow state machines in the lab designs.

---
 rtl/ee201_clk_div_prog.sv | 84 ++++++++
 tb/tb_ee201_clk_div_prog.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ee201_clk_div_prog.sv
// Programmable glitch-free clock/tick divider with a shadowed divisor that is
// swapped in only at a period boundary, so a running period never gets cut short.
module ee201_clk_div_prog #(
    parameter int WIDTH       = 32,
    parameter int DEFAULT_DIV = 1666667
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Mode,
    input  logic [WIDTH-1:0] DivIn,
    input  logic             DivLoad,
    output logic             ClkOut,
    output logic             Tick,
    output logic             LoadPending
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    // (n+1)>>1 with one extra bit so n = 2^WIDTH-1 cannot overflow
    function automatic logic [WIDTH-1:0] half_of(input logic [WIDTH-1:0] n);
        logic [WIDTH:0] s;
        s = {1'b0, n} + (WIDTH+1)'(1);
        return WIDTH'(s >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] n);
        return (n < TWO) ? TWO : n;
    endfunction

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] half_act;
    logic [WIDTH-1:0] div_shadow;
    logic             wrap;
    logic             apply;

    always_comb begin
        wrap      = En && (count == div_act - ONE);
        apply     = wrap && LoadPending;
        count_nxt = count;
        if (En) begin
            count_nxt = wrap ? '0 : count + ONE;
        end
    end

    // Outputs are registered from the next-state count, so they update on the same edge as count
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count       <= '0;
            div_act     <= DEF_DIV;
            half_act    <= half_of(DEF_DIV);
            div_shadow  <= DEF_DIV;
            LoadPending <= 1'b0;
            ClkOut      <= 1'b0;
            Tick        <= 1'b0;
        end else begin
            if (En) begin
                count  <= count_nxt;
                Tick   <= wrap;
                ClkOut <= Mode ? wrap : (count_nxt >= half_act);
            end else begin
                Tick <= 1'b0;
            end

            if (apply) begin
                div_act  <= div_shadow;
                half_act <= half_of(div_shadow);
            end

            // A load on a wrap edge lands in the shadow and waits for the following wrap
            if (DivLoad) begin
                div_shadow  <= clamp_div(DivIn);
                LoadPending <= 1'b1;
            end else if (apply) begin
                LoadPending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ee201_clk_div_prog.sv
// Bench for ee201_clk_div_prog: constant vector table, directed corner sequences,
// and randomized traffic against a period/position reference model.
module tb_ee201_clk_div_prog;

    localparam int W   = 8;
    localparam int DEF = 4;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         En;
    logic         Mode;
    logic [W-1:0] DivIn;
    logic         DivLoad;
    logic         ClkOut;
    logic         Tick;
    logic         LoadPending;

    ee201_clk_div_prog #(
        .WIDTH      (W),
        .DEFAULT_DIV(DEF)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .En         (En),
        .Mode       (Mode),
        .DivIn      (DivIn),
        .DivLoad    (DivLoad),
        .ClkOut     (ClkOut),
        .Tick       (Tick),
        .LoadPending(LoadPending)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    // Reference: position within the current period, period length, pending shadow
    int m_pos    = 0;
    int m_n      = DEF;
    int m_shadow = DEF;
    bit m_pend   = 1'b0;
    bit m_clk    = 1'b0;
    bit m_tick   = 1'b0;

    typedef struct {
        bit         rst;
        bit         en;
        bit         md;
        bit         ld;
        logic [7:0] dv;
        bit         e_clk;
        bit         e_tick;
        bit         e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit rst, bit en, bit md, bit ld, int dv,
                                bit e_clk, bit e_tick, bit e_pend);
        vec_t t;
        t.rst = rst; t.en = en; t.md = md; t.ld = ld; t.dv = 8'(dv);
        t.e_clk = e_clk; t.e_tick = e_tick; t.e_pend = e_pend;
        return t;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input bit md, input bit ld, input int dv);
        bit apply;
        if (r) begin
            m_pos = 0; m_n = DEF; m_shadow = DEF; m_pend = 0; m_clk = 0; m_tick = 0;
        end else begin
            if (en) begin
                m_pos  = (m_pos + 1) % m_n;
                m_tick = (m_pos == 0);
                m_clk  = md ? m_tick : (m_pos >= (m_n + 1) / 2);
            end else begin
                m_tick = 0;
            end
            apply = m_tick && m_pend;
            if (apply) m_n = m_shadow;
            if (ld) begin
                m_shadow = (dv < 2) ? 2 : dv;
                m_pend   = 1;
            end else if (apply) begin
                m_pend = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit en, input bit md, input bit ld, input int dv);
        Reset   = r;
        En      = en;
        Mode    = md;
        DivLoad = ld;
        DivIn   = W'(dv);
        @(posedge Clk);
        model_edge(r, en, md, ld, dv);
        #1;
        check("mdl_clkout", ClkOut, m_clk);
        check("mdl_tick", Tick, m_tick);
        check("mdl_pending", LoadPending, m_pend);
    endtask

    task automatic measure(input string name, input int exp);
        bit ok;
        int p;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 0, 0, 0);
            if (Tick === 1'b1) begin ok = 1; break; end
        end
        p = 0;
        if (ok) begin
            ok = 0;
            for (int i = 0; i < 300; i++) begin
                step(0, 1, 0, 0, 0);
                p++;
                if (Tick === 1'b1) begin ok = 1; break; end
            end
        end
        checks++;
        if (!ok || p != exp) begin
            failures++;
            $display("FAIL %s period actual=%0d required=%0d (tick seen=%0d)", name, p, exp, ok);
        end
    endtask

    initial begin
        Reset = 1'b1; En = 1'b0; Mode = 1'b0; DivLoad = 1'b0; DivIn = '0;

        // Default period N=4
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 1; k <= 12; k++)
            vecs.push_back(mk(0, 1, 0, 0, 0, (k % 4) >= 2, (k % 4) == 0, 0));
        // Mid-period load of 5 on edge 3
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 5, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
        for (int k = 5; k <= 14; k++)
            vecs.push_back(mk(0, 1, 0, 0, 0, ((k - 4) % 5) >= 3, ((k - 4) % 5) == 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].md, vecs[i].ld, int'(vecs[i].dv));
            check($sformatf("vec%0d_clkout", i), ClkOut, vecs[i].e_clk);
            check($sformatf("vec%0d_tick", i), Tick, vecs[i].e_tick);
            check($sformatf("vec%0d_pending", i), LoadPending, vecs[i].e_pend);
        end

        // Load coincident with the wrap on edge 4 is held until edge 8
        step(1, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 6);
        check("coinc_tick4", Tick, 1'b1);
        check("coinc_pend4", LoadPending, 1'b1);
        for (int k = 5; k <= 7; k++) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        check("coinc_tick8", Tick, 1'b1);
        check("coinc_pend8", LoadPending, 1'b0);
        measure("coinc_new_period", 6);

        // Double load before the wrap: last one wins
        step(0, 1, 0, 1, 3);
        step(0, 1, 0, 1, 7);
        measure("double_load_period", 7);

        // Clamp of 0 and 1 to 2
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 1);
        measure("clamp_period", 2);
        step(0, 1, 0, 0, 0);
        check("clamp_clk_hi", ClkOut, 1'b1);
        step(0, 1, 0, 0, 0);
        check("clamp_clk_lo", ClkOut, 1'b0);
        check("clamp_tick", Tick, 1'b1);

        // Enable freeze for 5 cycles mid-period
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 0, 0, 0);
            check($sformatf("freeze%0d_clk", k), ClkOut, 1'b1);
            check($sformatf("freeze%0d_tick", k), Tick, 1'b0);
        end
        step(0, 1, 0, 0, 0);
        check("resume_clk", ClkOut, 1'b1);
        check("resume_notick", Tick, 1'b0);
        step(0, 1, 0, 0, 0);
        check("resume_tick", Tick, 1'b1);

        // Pulse mode: ClkOut follows the tick
        step(1, 0, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            step(0, 1, 1, 0, 0);
            check($sformatf("pulse%0d_clk", k), ClkOut, (k % 4) == 0);
        end

        // Reset mid-period with a pending load
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 9);
        check("rst_pre_pend", LoadPending, 1'b1);
        step(1, 1, 0, 0, 0);
        check("rst_clk", ClkOut, 1'b0);
        check("rst_tick", Tick, 1'b0);
        check("rst_pend", LoadPending, 1'b0);
        measure("rst_default_period", DEF);

        // Randomized traffic against the reference model
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 85,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 6,
                 int'($urandom_range(0, 12)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
